// File: rtl/timer_seq_pkg.sv
// ---------------------------------------------------------------------------
// timer_seq_pkg: shared FSM states, slave register map and control bits.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package timer_seq_pkg;

  typedef logic [2:0] tmr_addr_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_PL    = 4'd1,
    ST_WR_PH    = 4'd2,
    ST_WR_CTL   = 4'd3,
    ST_CLR_ST   = 4'd4,
    ST_WR_STOP  = 4'd5,
    ST_SNAP_WR  = 4'd6,
    ST_SNAP_RL  = 4'd7,
    ST_SNAP_RH  = 4'd8,
    ST_SNAP_CAP = 4'd9
  } state_t;

  localparam tmr_addr_t c_addr_status   = 3'd0;
  localparam tmr_addr_t c_addr_control  = 3'd1;
  localparam tmr_addr_t c_addr_period_l = 3'd2;
  localparam tmr_addr_t c_addr_period_h = 3'd3;
  localparam tmr_addr_t c_addr_snap_l   = 3'd4;
  localparam tmr_addr_t c_addr_snap_h   = 3'd5;

  localparam int c_ctrl_ito   = 0;
  localparam int c_ctrl_cont  = 1;
  localparam int c_ctrl_start = 2;
  localparam int c_ctrl_stop  = 3;

  // The interrupt enable is always kept set so stop never masks a pending timeout.
  function automatic logic [15:0] ctrl_word(logic cont, logic start, logic stop);
    logic [15:0] w;
    w               = '0;
    w[c_ctrl_ito]   = 1'b1;
    w[c_ctrl_cont]  = cont;
    w[c_ctrl_start] = start;
    w[c_ctrl_stop]  = stop;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_sequencer_if.sv
// ---------------------------------------------------------------------------
// timer_sequencer_if: master/slave bus to the interval-timer register slave.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface timer_sequencer_if;
  import timer_seq_pkg::*;

  tmr_addr_t   tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_readdata, tmr_irq
  );

  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_readdata, tmr_irq
  );
endinterface

`default_nettype wire

// File: rtl/timer_sequencer.sv
// ---------------------------------------------------------------------------
// timer_sequencer: arbitrates irq/stop/config/snapshot requests into register
// accesses on an interval-timer slave. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              cfg_req,
  input  wire logic [31:0]       cfg_period,
  input  wire logic              cfg_cont,
  input  wire logic              stop_req,
  input  wire logic              snap_req,
  output      logic              ready,
  output      logic              snap_valid,
  output      logic [31:0]       snap_value,
  output      logic              tick,
  output      logic [TICK_W-1:0] tick_count,
  timer_sequencer_if.master      tmr
);

  state_t            state_q, state_d;
  logic [31:0]       period_q, period_d;
  logic              cont_q, cont_d;
  tmr_addr_t         addr_q, addr_d;
  logic              cs_q, cs_d;
  logic              wr_n_q, wr_n_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              tick_q;
  logic [TICK_W-1:0] tick_count_q;
  logic              snap_valid_q;
  logic [31:0]       snap_q;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cont_d   = cont_q;
    case (state_q)
      ST_IDLE: begin
        if (tmr.tmr_irq) begin
          state_d = ST_CLR_ST;
        end else if (stop_req) begin
          state_d = ST_WR_STOP;
        end else if (cfg_req) begin
          state_d  = ST_WR_PL;
          period_d = cfg_period;
          cont_d   = cfg_cont;
        end else if (snap_req) begin
          state_d = ST_SNAP_WR;
        end
      end
      ST_WR_PL:   state_d = ST_WR_PH;
      ST_WR_PH:   state_d = ST_WR_CTL;
      ST_SNAP_WR: state_d = ST_SNAP_RL;
      ST_SNAP_RL: state_d = ST_SNAP_RH;
      ST_SNAP_RH: state_d = ST_SNAP_CAP;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registered bus lines up with state_q.
  always_comb begin
    addr_d  = '0;
    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    wdata_d = '0;
    case (state_d)
      ST_WR_PL: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = c_addr_period_l; wdata_d = period_d[15:0];
      end
      ST_WR_PH: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = c_addr_period_h; wdata_d = period_d[31:16];
      end
      ST_WR_CTL: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = c_addr_control;
        wdata_d = ctrl_word(cont_d, 1'b1, 1'b0);
      end
      ST_CLR_ST: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = c_addr_status;
      end
      ST_WR_STOP: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = c_addr_control;
        wdata_d = ctrl_word(1'b0, 1'b0, 1'b1);
      end
      ST_SNAP_WR: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = c_addr_snap_l;
      end
      ST_SNAP_RL: begin
        cs_d = 1'b1; addr_d = c_addr_snap_l;
      end
      ST_SNAP_RH, ST_SNAP_CAP: begin
        cs_d = 1'b1; addr_d = c_addr_snap_h;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      addr_q       <= '0;
      cs_q         <= 1'b0;
      wr_n_q       <= 1'b1;
      wdata_q      <= '0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      snap_valid_q <= 1'b0;
      snap_q       <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wr_n_q       <= wr_n_d;
      wdata_q      <= wdata_d;
      tick_q       <= (state_q == ST_CLR_ST);
      snap_valid_q <= (state_q == ST_SNAP_CAP);
      if (state_q == ST_CLR_ST) begin
        tick_count_q <= tick_count_q + TICK_W'(1);
      end
      // Read data lags the address by one cycle: RH sees snap_l, CAP sees snap_h.
      if (state_q == ST_SNAP_RH) begin
        snap_q[15:0] <= tmr.tmr_readdata;
      end
      if (state_q == ST_SNAP_CAP) begin
        snap_q[31:16] <= tmr.tmr_readdata;
      end
    end
  end

  assign ready              = (state_q == ST_IDLE);
  assign snap_valid         = snap_valid_q;
  assign snap_value         = snap_q;
  assign tick               = tick_q;
  assign tick_count         = tick_count_q;
  assign tmr.tmr_address    = addr_q;
  assign tmr.tmr_chipselect = cs_q;
  assign tmr.tmr_write_n    = wr_n_q;
  assign tmr.tmr_writedata  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timer_sequencer: directed stimulus with a queued scoreboard of bus writes,
// ticks and snapshots. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_timer_sequencer;

  localparam int EV_WR   = 0;
  localparam int EV_TICK = 1;
  localparam int EV_SNAP = 2;

  typedef struct {
    string       name;
    int          kind;
    int          cyc;
    logic [2:0]  addr;
    logic [31:0] data;
    bit          care;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_req, cfg_cont, stop_req, snap_req;
  logic [31:0] cfg_period;
  logic        ready, snap_valid, tick;
  logic [31:0] snap_value;
  logic [15:0] tick_count;

  logic        ready2, snap_valid2, tick2;
  logic [31:0] snap_value2;
  logic [2:0]  tick_count2;
  logic        irq2;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  ev_t         exp_q[$];

  logic        irq_q = 1'b0;
  logic        irq_raise;
  logic [31:0] s_counter;
  logic [15:0] s_snap_l = '0;
  logic [15:0] s_snap_h = '0;

  logic [2:0]  exp2 = '0;
  int          ticks2 = 0;
  bit          wrapped2 = 1'b0;

  timer_sequencer_if bus ();
  timer_sequencer_if bus2 ();

  timer_sequencer #(.TICK_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_req(cfg_req), .cfg_period(cfg_period),
    .cfg_cont(cfg_cont), .stop_req(stop_req), .snap_req(snap_req), .ready(ready),
    .snap_valid(snap_valid), .snap_value(snap_value), .tick(tick),
    .tick_count(tick_count), .tmr(bus.master)
  );

  // Narrow counter instance so wrap-around is reachable in a short run.
  timer_sequencer #(.TICK_W(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .cfg_req(1'b0), .cfg_period(32'h0),
    .cfg_cont(1'b0), .stop_req(1'b0), .snap_req(1'b0), .ready(ready2),
    .snap_valid(snap_valid2), .snap_value(snap_value2), .tick(tick2),
    .tick_count(tick_count2), .tmr(bus2.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave: writes land on the edge, read data is registered, irq holds until status write.
  assign bus.tmr_irq      = irq_q;
  assign bus2.tmr_irq     = irq2;
  assign bus2.tmr_readdata = '0;

  always @(posedge clk) begin
    if (irq_raise) irq_q <= 1'b1;
    if (bus.tmr_chipselect === 1'b1 && bus.tmr_write_n === 1'b0) begin
      if (bus.tmr_address == 3'd0) irq_q <= 1'b0;
      if (bus.tmr_address == 3'd4 || bus.tmr_address == 3'd5) begin
        s_snap_l <= s_counter[15:0];
        s_snap_h <= s_counter[31:16];
      end
    end
    case (bus.tmr_address)
      3'd4:    bus.tmr_readdata <= s_snap_l;
      3'd5:    bus.tmr_readdata <= s_snap_h;
      default: bus.tmr_readdata <= '0;
    endcase
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(string name, int kind, int c, logic [2:0] a, logic [31:0] d, bit care);
    ev_t e;
    e.name = name; e.kind = kind; e.cyc = c; e.addr = a; e.data = d; e.care = care;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(int kind, logic [2:0] a, logic [31:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: actual kind=%0d cyc=%0d addr=%0d data=%h required=no event",
               kind, cyc, a, d);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.addr != a || (e.care && e.data !== d)) begin
      n_errors++;
      $display("FAIL %s: actual kind=%0d cyc=%0d addr=%0d data=%h required kind=%0d cyc=%0d addr=%0d data=%h",
               e.name, kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (bus.tmr_chipselect === 1'b1 && bus.tmr_write_n === 1'b0)
      check_ev(EV_WR, bus.tmr_address, {16'h0, bus.tmr_writedata});
    if (tick === 1'b1)
      check_ev(EV_TICK, 3'd0, {16'h0, tick_count});
    if (snap_valid === 1'b1)
      check_ev(EV_SNAP, 3'd0, snap_value);
  end

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      exp2 = '0;
    end else if (tick2 === 1'b1) begin
      exp2 = 3'(exp2 + 3'd1);
      ticks2++;
      if (exp2 == 3'd0) wrapped2 = 1'b1;
      chk("narrow_tick_count", {29'h0, tick_count2}, {29'h0, exp2});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    reset_n = 1'b0; cfg_req = 1'b0; cfg_period = '0; cfg_cont = 1'b0;
    stop_req = 1'b0; snap_req = 1'b0; irq_raise = 1'b0; irq2 = 1'b0; s_counter = '0;
    step(3);
    chk("rst_ready",      {31'h0, ready}, 32'd1);
    chk("rst_chipselect", {31'h0, bus.tmr_chipselect}, 32'd0);
    chk("rst_write_n",    {31'h0, bus.tmr_write_n}, 32'd1);
    chk("rst_address",    {29'h0, bus.tmr_address}, 32'd0);
    chk("rst_writedata",  {16'h0, bus.tmr_writedata}, 32'd0);
    chk("rst_tick",       {31'h0, tick}, 32'd0);
    chk("rst_tick_count", {16'h0, tick_count}, 32'd0);
    chk("rst_snap_valid", {31'h0, snap_valid}, 32'd0);
    chk("rst_snap_value", snap_value, 32'd0);
    reset_n = 1'b1;
    step(2);

    // Held irq on the narrow instance: one tick every two cycles, count wraps 7 -> 0.
    irq2 = 1'b1;
    step(24);
    irq2 = 1'b0;
    step(4);

    // Config, continuous mode; inputs changed after acceptance must be ignored.
    cfg_period = 32'h0001_86A0; cfg_cont = 1'b1; cfg_req = 1'b1;
    a = cyc + 1;
    push("cfg1_period_l", EV_WR, a,     3'd2, 32'h86A0, 1'b1);
    push("cfg1_period_h", EV_WR, a + 1, 3'd3, 32'h0001, 1'b1);
    push("cfg1_control",  EV_WR, a + 2, 3'd1, 32'h0007, 1'b1);
    step(1);
    cfg_req = 1'b0; cfg_period = 32'hFFFF_FFFF; cfg_cont = 1'b0;
    step(2);
    chk("cfg1_ready_busy", {31'h0, ready}, 32'd0);
    step(1);
    chk("cfg1_ready_back", {31'h0, ready}, 32'd1);
    step(2);

    // Config, one-shot mode.
    cfg_period = 32'hDEAD_BEEF; cfg_cont = 1'b0; cfg_req = 1'b1;
    a = cyc + 1;
    push("cfg2_period_l", EV_WR, a,     3'd2, 32'hBEEF, 1'b1);
    push("cfg2_period_h", EV_WR, a + 1, 3'd3, 32'hDEAD, 1'b1);
    push("cfg2_control",  EV_WR, a + 2, 3'd1, 32'h0005, 1'b1);
    step(1);
    cfg_req = 1'b0;
    step(5);

    // Stop.
    stop_req = 1'b1;
    a = cyc + 1;
    push("stop_control", EV_WR, a, 3'd1, 32'h0009, 1'b1);
    step(1);
    stop_req = 1'b0;
    step(3);

    // Single irq: one status clear, one tick, no second service once it drops.
    irq_raise = 1'b1;
    step(1);
    irq_raise = 1'b0;
    a = cyc + 1;
    push("irq1_clear", EV_WR,   a,     3'd0, 32'h0000, 1'b1);
    push("irq1_tick",  EV_TICK, a + 1, 3'd0, 32'd1,    1'b1);
    step(8);
    chk("irq1_no_resvc", exp_q.size(), 32'd0);

    // irq, stop and cfg together: priority order with requests held until taken.
    irq_raise = 1'b1;
    step(1);
    irq_raise = 1'b0;
    stop_req = 1'b1; cfg_req = 1'b1; cfg_period = 32'h0000_1234; cfg_cont = 1'b1;
    a = cyc + 1;
    push("prio_clear",     EV_WR,   a,     3'd0, 32'h0000, 1'b1);
    push("prio_tick",      EV_TICK, a + 1, 3'd0, 32'd2,    1'b1);
    push("prio_stop",      EV_WR,   a + 2, 3'd1, 32'h0009, 1'b1);
    push("prio_period_l",  EV_WR,   a + 4, 3'd2, 32'h1234, 1'b1);
    push("prio_period_h",  EV_WR,   a + 5, 3'd3, 32'h0000, 1'b1);
    push("prio_control",   EV_WR,   a + 6, 3'd1, 32'h0007, 1'b1);
    step(3);
    stop_req = 1'b0;
    step(2);
    cfg_req = 1'b0;
    step(5);

    // Snapshots: spec value, then one with a non-zero high half.
    s_counter = 32'h0000_C34F; snap_req = 1'b1;
    a = cyc + 1;
    push("snap1_write", EV_WR,   a,     3'd4, 32'h0, 1'b0);
    push("snap1_value", EV_SNAP, a + 4, 3'd0, 32'h0000_C34F, 1'b1);
    step(1);
    snap_req = 1'b0;
    step(6);
    s_counter = 32'h1234_ABCD; snap_req = 1'b1;
    a = cyc + 1;
    push("snap2_write", EV_WR,   a,     3'd4, 32'h0, 1'b0);
    push("snap2_value", EV_SNAP, a + 4, 3'd0, 32'h1234_ABCD, 1'b1);
    step(1);
    snap_req = 1'b0;
    step(6);

    // Reset during WR_PH aborts the config with no control write.
    cfg_period = 32'h0005_0006; cfg_cont = 1'b0; cfg_req = 1'b1;
    a = cyc + 1;
    push("rstmid_period_l", EV_WR, a,     3'd2, 32'h0006, 1'b1);
    push("rstmid_period_h", EV_WR, a + 1, 3'd3, 32'h0005, 1'b1);
    step(1);
    cfg_req = 1'b0;
    step(1);
    reset_n = 1'b0;
    step(1);
    chk("rstmid_chipselect", {31'h0, bus.tmr_chipselect}, 32'd0);
    chk("rstmid_ready",      {31'h0, ready}, 32'd1);
    reset_n = 1'b1;
    step(6);

    chk("queue_drained",  exp_q.size(), 32'd0);
    chk("narrow_wrapped", {31'h0, wrapped2}, 32'd1);
    chk("narrow_ticks_ge8", {31'h0, (ticks2 >= 8)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 SHALL have parameter TICK_W, default 16, width of the timeout tick counter.
REQ-002 SHALL have port clk  in  1  sole clock.
REQ-003 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port cfg_req  in  1  request to load a period and start the timer.
REQ-005 SHALL have port cfg_period  in  32  period value, loaded into timer period_h:period_l.
REQ-006 SHALL have port cfg_cont  in  1  continuous-mode flag written with the start.
REQ-007 SHALL have port stop_req  in  1  request to stop the timer.
REQ-008 SHALL have port snap_req  in  1  request to snapshot and read the timer counter.
REQ-009 SHALL have port ready  out  1  high in IDLE only; requests are sampled only when ready=1.
REQ-010 SHALL have port snap_valid  out  1  one-cycle pulse, snap_value valid.
REQ-011 SHALL have port snap_value  out  32  captured counter value, {high16, low16}.
REQ-012 SHALL have port tick  out  1  one-cycle pulse per serviced timeout.
REQ-013 SHALL have port tick_count  out  TICK_W  serviced-timeout count, wraps modulo 2^TICK_W.
REQ-014 SHALL have ports tmr_address (out 3), tmr_chipselect (out 1), tmr_write_n (out 1), tmr_writedata (out 16): master side of the interval-timer slave.
REQ-015 SHALL have ports tmr_readdata (in 16) and tmr_irq (in 1): slave read data and level interrupt.

Function
REQ-016 Slave model: a write completes in the cycle it is presented, with no waitrequest; tmr_readdata in cycle N+1 reflects tmr_address in cycle N.
REQ-017 Slave register map: 0 status (any write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h (a write captures the snapshot).
REQ-018 FSM states: IDLE, WR_PL, WR_PH, WR_CTL, CLR_ST, WR_STOP, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP; each non-IDLE state lasts exactly one cycle.
REQ-019 IDLE arbitration priority: tmr_irq, then stop_req, then cfg_req, then snap_req; a lower-priority request that is not taken is not latched and must be held by the requester.
REQ-020 Config sequence: WR_PL writes cfg_period[15:0] to addr 2, WR_PH writes cfg_period[31:16] to addr 3, WR_CTL writes 0x5 | (cfg_cont<<1) to addr 1, then the FSM returns to IDLE.
REQ-021 cfg_period and cfg_cont SHALL be registered in the cycle the request is accepted; changes afterwards have no effect.
REQ-022 Stop sequence: WR_STOP writes 0x9 (STOP|ITO) to addr 1, then IDLE; the interrupt enable is kept.
REQ-023 Irq service: CLR_ST writes 0 to addr 0; tick pulses, and tick_count increments, in the cycle after CLR_ST; the FSM then returns to IDLE.
REQ-024 Snapshot sequence: SNAP_WR writes to addr 4; SNAP_RL reads addr 4; SNAP_RH reads addr 5 and captures tmr_readdata into low16; SNAP_CAP captures tmr_readdata into high16; snap_valid pulses in the following cycle.
REQ-025 A tmr_irq that arrives mid-sequence SHALL be serviced on the first IDLE cycle after the sequence, because the irq level persists until cleared.
REQ-026 tmr_chipselect is 1 only in non-IDLE states; tmr_write_n is 0 only in write states; in IDLE, tmr_address=0 and tmr_writedata=0.
REQ-027 All outputs SHALL be registered, except ready, which decodes the state.

Reset
REQ-028 While reset_n=0 at a clk edge: state=IDLE, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, tick=0, tick_count=0, snap_valid=0, snap_value=0.
REQ-029 Reset asserted mid-sequence SHALL abort it with no further bus access; the timer slave is not reprogrammed.

Structure
REQ-030 The state enumeration, the register addresses (0-5) and the control bit positions SHALL live in a shared package timer_seq_pkg.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 cfg_req with period 0x0001_86A0 and cont=1 -> writes addr2=0x86A0, addr3=0x0001, addr1=0x0007 on consecutive cycles, and ready returns 1 on the 4th cycle.
REQ-033 tmr_irq held high -> one addr0 write, tick pulses once, tick_count 0->1; irq drops -> no second service.
REQ-034 tmr_irq, stop_req and cfg_req raised in the same cycle -> order is CLR_ST, then WR_STOP, then the config sequence, with requests held.
REQ-035 snap_req, with slave counter 0x0000_C34F -> snap_valid pulses 5 cycles after acceptance with snap_value=0x0000C34F.
REQ-036 tick_count at 0xFFFF with TICK_W=16, then an irq -> tick_count=0x0000 and tick pulses.
REQ-037 reset_n low during WR_PH -> next cycle chipselect=0, state IDLE, and no WR_CTL is issued.
